// File: rtl/lbp_pkg.sv
// Shared types and sizes for the two-engine LBP memory arbiter.
package lbp_pkg;

  localparam int unsigned IMG_W    = 128;
  localparam int unsigned IMG_H    = 128;
  localparam int unsigned AW       = 14;
  localparam int unsigned DW       = 8;
  localparam int unsigned READ_LAT = 2;

  typedef logic [0:0] eng_id_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_beat_t;

  function automatic logic [1:0] id_onehot(eng_id_t id);
    return (id == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; a locked requester keeps the grant
// while it still requests and was the most recent winner.
module rr_arb2
  import lbp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt_c,
  output eng_id_t    id_c,
  output logic       any_c
);

  eng_id_t last;

  always_comb begin
    any_c = en & (|req);
    id_c  = eng_id_t'(req[1]);
    if (lock[last] && req[last]) begin
      id_c = last;
    end else if (req == 2'b11) begin
      id_c = ~last;
    end
    gnt_c = any_c ? id_onehot(id_c) : 2'b00;
  end

  // last = 1 out of reset so engine 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (any_c) begin
      last <= id_c;
    end
  end

endmodule

// File: rtl/lbp_mem_arbiter.sv
// Shares one gray-image read port and one LBP write port between two engines,
// and raises a sticky finish once both engines are done and writes drained.
module lbp_mem_arbiter
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  input  logic [1:0]    rq_req,
  input  logic [1:0]    rq_lock,
  input  logic [AW-1:0] rq_addr0,
  input  logic [AW-1:0] rq_addr1,
  output logic [1:0]    rq_gnt,
  output logic [1:0]    rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic [1:0]    wr_valid,
  input  logic [AW-1:0] wr_addr0,
  input  logic [AW-1:0] wr_addr1,
  input  logic [DW-1:0] wr_data0,
  input  logic [DW-1:0] wr_data1,
  output logic [1:0]    wr_gnt,
  input  logic [1:0]    done,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [DW-1:0] lbp_data,
  output logic          finish
);

  eng_id_t  rd_id;
  eng_id_t  wr_id;
  logic     rd_any;
  logic     wr_any;
  eng_id_t  tag_id;
  wr_beat_t wr_beat_c;

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .en    (gray_ready),
    .req   (rq_req),
    .lock  (rq_lock),
    .gnt_c (rq_gnt),
    .id_c  (rd_id),
    .any_c (rd_any)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .req   (wr_valid),
    .lock  (2'b00),
    .gnt_c (wr_gnt),
    .id_c  (wr_id),
    .any_c (wr_any)
  );

  always_comb begin
    wr_beat_c = '{addr: wr_addr0, data: wr_data0};
    if (wr_id == 1'b1) begin
      wr_beat_c = '{addr: wr_addr1, data: wr_data1};
    end
  end

  assign rd_data = gray_data;

  // Tag pipe: stage 1 rides with gray_req, stage 2 is rd_valid itself
  always_ff @(posedge clk) begin
    if (!reset) begin
      gray_req  <= 1'b0;
      gray_addr <= '0;
      tag_id    <= '0;
      rd_valid  <= 2'b00;
    end else begin
      gray_req <= rd_any;
      tag_id   <= rd_id;
      if (rd_any) begin
        gray_addr <= (rd_id == 1'b1) ? rq_addr1 : rq_addr0;
      end
      rd_valid <= gray_req ? id_onehot(tag_id) : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
    end else begin
      lbp_valid <= wr_any;
      if (wr_any) begin
        lbp_addr <= wr_beat_c.addr;
        lbp_data <= wr_beat_c.data;
      end
    end
  end

  // Waits for both the grant stage and the output stage to be empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      finish <= 1'b0;
    end else if ((done == 2'b11) && !wr_any && !lbp_valid) begin
      finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lbp_mem_arbiter.sv
// Directed plus randomized bench for lbp_mem_arbiter against a cycle-level reference model.
module tb_lbp_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gray_ready = 1'b1;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data = 8'h00;
  logic [1:0]  rq_req = 2'b00;
  logic [1:0]  rq_lock = 2'b00;
  logic [13:0] rq_addr0 = '0;
  logic [13:0] rq_addr1 = '0;
  logic [1:0]  rq_gnt;
  logic [1:0]  rd_valid;
  logic [7:0]  rd_data;
  logic [1:0]  wr_valid = 2'b00;
  logic [13:0] wr_addr0 = '0;
  logic [13:0] wr_addr1 = '0;
  logic [7:0]  wr_data0 = '0;
  logic [7:0]  wr_data1 = '0;
  logic [1:0]  wr_gnt;
  logic [1:0]  done = 2'b00;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;

  int n_checks = 0;
  int n_errors = 0;

  lbp_mem_arbiter dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .rq_req(rq_req), .rq_lock(rq_lock),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1), .rq_gnt(rq_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt), .done(done),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // Gray image memory: data appears the cycle after a read strobe
  always @(posedge clk) begin
    if (gray_req) gray_data <= mem_f(gray_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner under the stated policy, -1 when nobody is granted
  function automatic int pick(logic [1:0] req, logic [1:0] lock, int last, logic en);
    if (!en || req == 2'b00) return -1;
    if (lock[last] && req[last]) return last;
    if (req == 2'b11) return 1 - last;
    return req[0] ? 0 : 1;
  endfunction

  function automatic logic [1:0] as_gnt(int g);
    if (g < 0) return 2'b00;
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  typedef struct {
    int          due;
    int          id;
    logic [13:0] addr;
  } rd_t;

  rd_t         pend[$];
  int          cyc = 0;
  int          m_last_rd = 1;
  int          m_last_wr = 1;
  logic        m_gray_req = 1'b0;
  logic [13:0] m_gray_addr = '0;
  logic [1:0]  m_rd_valid = 2'b00;
  logic [7:0]  m_rd_data = '0;
  logic        m_lbp_valid = 1'b0;
  logic [13:0] m_lbp_addr = '0;
  logic [7:0]  m_lbp_data = '0;
  logic        m_finish = 1'b0;

  always @(negedge clk) begin
    int rg;
    int wg;
    rg = pick(rq_req, rq_lock, m_last_rd, gray_ready);
    wg = pick(wr_valid, 2'b00, m_last_wr, 1'b1);
    if (reset) begin
      check_eq("gray_req", 32'(gray_req), 32'(m_gray_req));
      check_eq("gray_addr", 32'(gray_addr), 32'(m_gray_addr));
      check_eq("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      if (m_rd_valid != 2'b00) check_eq("rd_data", 32'(rd_data), 32'(m_rd_data));
      check_eq("lbp_valid", 32'(lbp_valid), 32'(m_lbp_valid));
      check_eq("lbp_addr", 32'(lbp_addr), 32'(m_lbp_addr));
      check_eq("lbp_data", 32'(lbp_data), 32'(m_lbp_data));
      check_eq("finish", 32'(finish), 32'(m_finish));
      check_eq("rq_gnt", 32'(rq_gnt), 32'(as_gnt(rg)));
      check_eq("wr_gnt", 32'(wr_gnt), 32'(as_gnt(wg)));
    end
    if (!reset) begin
      pend.delete();
      m_last_rd = 1; m_last_wr = 1;
      m_gray_req = 1'b0; m_gray_addr = '0; m_rd_valid = 2'b00;
      m_lbp_valid = 1'b0; m_lbp_addr = '0; m_lbp_data = '0; m_finish = 1'b0;
    end else begin
      if (done == 2'b11 && wg < 0 && !m_lbp_valid) m_finish = 1'b1;
      m_rd_valid = 2'b00;
      while (pend.size() > 0 && pend[0].due == cyc + 1) begin
        m_rd_valid = as_gnt(pend[0].id);
        m_rd_data  = mem_f(pend[0].addr);
        void'(pend.pop_front());
      end
      m_gray_req = (rg >= 0);
      if (rg >= 0) begin
        m_gray_addr = (rg == 1) ? rq_addr1 : rq_addr0;
        m_last_rd = rg;
        pend.push_back('{due: cyc + 2, id: rg, addr: m_gray_addr});
      end
      m_lbp_valid = (wg >= 0);
      if (wg >= 0) begin
        m_lbp_addr = (wg == 1) ? wr_addr1 : wr_addr0;
        m_lbp_data = (wg == 1) ? wr_data1 : wr_data0;
        m_last_wr = wg;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    rq_addr0 = 14'h0000; rq_addr1 = 14'h2000; rq_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("alt_gnt", 32'(rq_gnt), (i % 2 == 1) ? 32'd2 : 32'd1);
      tick();
    end
    rq_req = 2'b00;
    tick();

    rq_req = 2'b11; rq_lock = 2'b01;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("lock_gnt", 32'(rq_gnt), 32'd1);
      tick();
      rq_addr0 = rq_addr0 + 14'd1;
    end
    rq_req = 2'b10; rq_lock = 2'b00;
    @(negedge clk);
    check_eq("post_lock", 32'(rq_gnt), 32'd2);
    tick();

    gray_ready = 1'b0; rq_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("nrdy_gnt", 32'(rq_gnt), 32'd0);
      if (i > 0) check_eq("nrdy_req", 32'(gray_req), 32'd0);
      tick();
    end
    gray_ready = 1'b1;
    @(negedge clk);
    check_eq("rdy_first", 32'(rq_gnt), 32'd1);
    tick();
    rq_req = 2'b00;
    tick();
    @(negedge clk);
    check_eq("rdy_rdv", 32'(rd_valid), 32'd1);
    tick();

    wr_addr0 = 14'd129; wr_data0 = 8'h5A; wr_addr1 = 14'd8321; wr_data1 = 8'hC3;
    wr_valid = 2'b11; done = 2'b11;
    @(negedge clk);
    check_eq("wr_first", 32'(wr_gnt), 32'd1);
    tick();
    wr_valid = 2'b10;
    @(negedge clk);
    check_eq("wr_second", 32'(wr_gnt), 32'd2);
    check_eq("lbp0_v", 32'(lbp_valid), 32'd1);
    check_eq("lbp0_a", 32'(lbp_addr), 32'd129);
    check_eq("lbp0_d", 32'(lbp_data), 32'h5A);
    tick();
    wr_valid = 2'b00;
    @(negedge clk);
    check_eq("lbp1_v", 32'(lbp_valid), 32'd1);
    check_eq("lbp1_a", 32'(lbp_addr), 32'd8321);
    check_eq("lbp1_d", 32'(lbp_data), 32'hC3);
    check_eq("fin_early", 32'(finish), 32'd0);
    tick();
    @(negedge clk);
    check_eq("lbp_idle", 32'(lbp_valid), 32'd0);
    check_eq("fin_wait", 32'(finish), 32'd0);
    tick();
    @(negedge clk);
    check_eq("fin_set", 32'(finish), 32'd1);
    tick();
    done = 2'b00;
    repeat (3) tick();
    @(negedge clk);
    check_eq("fin_sticky", 32'(finish), 32'd1);
    tick();

    rq_req = 2'b11;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; rq_req = 2'b00;
    @(negedge clk);
    check_eq("rst_rdv", 32'(rd_valid), 32'd0);
    check_eq("rst_req", 32'(gray_req), 32'd0);
    check_eq("rst_fin", 32'(finish), 32'd0);
    tick();
    rq_req = 2'b11;
    @(negedge clk);
    check_eq("rst_rdv2", 32'(rd_valid), 32'd0);
    check_eq("rst_tie", 32'(rq_gnt), 32'd1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) != 0);
      gray_ready = ($urandom_range(0, 7) != 0);
      rq_req     = 2'($urandom);
      rq_lock    = 2'($urandom);
      rq_addr0   = 14'($urandom);
      rq_addr1   = 14'($urandom);
      wr_valid   = 2'($urandom);
      wr_addr0   = 14'($urandom);
      wr_addr1   = 14'($urandom);
      wr_data0   = 8'($urandom);
      wr_data1   = 8'($urandom);
      done       = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom);
      tick();
    end
    reset = 1'b1; rq_req = 2'b00; wr_valid = 2'b00;
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lbp_mem_arbiter.md
# lbp_mem_arbiter

Shares the single gray-image read port and the single LBP-result write port between two LBP engines (engine 0: image rows 0–63, engine 1: rows 64–127). It sits between the engines and the testbench memory models. Reads use round-robin arbitration with a lock that keeps a 3×3 window fetch atomic. Writes are merged into the one lbp_* output, and `finish` is raised once both engines report done.

## Interface
- AW, 14, gray/lbp address width (128×128 image)
- DW, 8, pixel / LBP code width
---
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- gray_ready  in  1  memory loaded and able to accept reads (level)
- gray_req  out  1  read strobe to memory
- gray_addr  out  AW  read address
- gray_data  in  DW  read data, valid the cycle after gray_req is seen high
- rq_req  in  2  per-engine read request, held until granted
- rq_lock  in  2  per-engine lock, keeps the grant while this engine holds it
- rq_addr0 / rq_addr1  in  AW  per-engine read address
- rq_gnt  out  2  combinational read grant; the engine advances its address on it
- rd_valid  out  2  per-engine read-data strobe
- rd_data  out  DW  read data (gray_data passed through)
- wr_valid  in  2  per-engine result valid, held until wr_gnt
- wr_addr0 / wr_addr1  in  AW  result address
- wr_data0 / wr_data1  in  DW  result code
- wr_gnt  out  2  combinational write grant
- done  in  2  engine finished, level
- lbp_valid  out  1  result write strobe
- lbp_addr  out  AW  result address
- lbp_data  out  DW  result code
- finish  out  1  all results written, sticky

## Operation
- Read arbiter: at most one grant per cycle, and only while gray_ready=1.
  - Owner is the lock holder when rq_lock[i] & rq_req[i] & last_rd==i.
  - Otherwise, if both engines request, grant the one ≠ last_rd. Otherwise grant the sole requester.
  - last_rd updates on every grant.
- rq_lock without rq_req has no effect. Dropping rq_req releases the lock immediately.
- Granted request: gray_req/gray_addr are registered. The owner ID enters a 2-stage tag pipe. rd_valid[tag] is asserted when gray_data for that read returns.
- Write arbiter: separate round-robin pointer last_wr, same rule with no lock. On a grant, lbp_valid/addr/data are registered from the granted engine.
- finish: set when done==2'b11 and there is no granted write in the current cycle and lbp_valid=0. It then holds until reset.
- gray_ready falling: no new grants. Reads already in flight still deliver rd_valid.

## Timing
- Reset (reset=0 at a clk edge) sets: gray_req=0, gray_addr=0, rd_valid=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0, last_rd=1, last_wr=1 (so engine 0 wins the first tie), and clears the tag pipe. Reset mid-operation discards in-flight reads.
- Read latency: grant in cycle T → gray_req=1 in T+1 → gray_data and rd_valid[i] in T+2. Throughput is one read per cycle.
- Write latency: wr_gnt in T → lbp_valid=1 in T+1 for exactly one cycle per grant. Back-to-back grants give a continuous lbp_valid.
- rq_gnt/wr_gnt are pure functions of inputs and the pointer registers. There is no comb path from gray_data to any grant.
- gray_req is high only in cycles following a grant. gray_addr holds its value when idle.

## Structure
- Package lbp_pkg: IMG_W=128, IMG_H=128, AW, DW, READ_LAT=2, engine-ID type (1 bit).
- Sub-module rr_arb2: 2-input round-robin with optional lock. It is instantiated twice (read side with lock, write side with lock tied 0).
- Top module holds the tag pipe, output registers and the finish logic.

## Test plan
- Both rq_req=1, addrs 0x0000/0x2000, no lock → grants alternate 0,1,0,1. gray_addr alternates the two addresses. rd_valid alternates 2 cycles after each grant.
- Engine 0 with rq_lock=1 issues 9 reads while engine 1 requests constantly → 9 consecutive grants to 0, then engine 1 is granted on the cycle after lock/req drops.
- gray_ready=0 with both requesting → rq_gnt=0 and gray_req=0. When gray_ready rises, the first grant goes to engine 0 and rd_valid[0] follows 2 cycles later.
- Both wr_valid=1 (addr 129/data 0x5A; addr 8321/data 0xC3) → lbp_valid high for 2 cycles, with engine 0's write first and then engine 1's, each one cycle after its grant.
- done=2'b11 while a write is pending → finish rises only after the last lbp_valid and stays 1 after done drops.
- reset=0 mid-read (tag pipe full) → the next cycle has all outputs at their reset values, no rd_valid from the discarded reads, and engine 0 wins the next tie.
